// File: rtl/mdu_share_ctrl_pkg.sv
// mdu_pkg: shared types and defaults for the shared M-extension unit controller
package mdu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [2:0] {
    MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
    DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111
  } mdu_op_t;
endpackage

// File: rtl/mdu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin pick; the pointer favours the loser of the last grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       pick
);
  logic rr_ptr;
  assign pick = req[1] & (~req[0] | rr_ptr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= 1'b0;
    else if (en) rr_ptr <= ~pick;
endmodule

// File: rtl/mdu_share_ctrl.sv
// mdu_share_ctrl: arbitrates two EX stages onto one multi-cycle MDU with start/done handshake and timeout
module mdu_share_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  input  logic [1:0][2:0]      req_op,
  input  logic [1:0][XLEN-1:0] req_a,
  input  logic [1:0][XLEN-1:0] req_b,
  output logic [1:0]           stall_out,
  output logic [1:0]           rsp_valid,
  output logic [XLEN-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 mdu_start,
  output logic [2:0]           mdu_op,
  output logic [XLEN-1:0]      mdu_a,
  output logic [XLEN-1:0]      mdu_b,
  input  logic                 mdu_done,
  input  logic [XLEN-1:0]      mdu_result,
  output logic                 busy
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state, state_nx;
  logic grant, pick, err, timeout, resp;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] res;
  mdu_op_t op_q;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req_valid),
    .en   (state == IDLE && |req_valid),
    .pick (pick)
  );
  assign timeout = cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state == IDLE  ? (|req_valid ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? ((mdu_done | timeout) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant <= 1'b0;
      op_q <= MUL;
      mdu_a <= '0;
      mdu_b <= '0;
      cnt <= '0;
      res <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          grant <= pick;
          op_q <= mdu_op_t'(req_op[pick]);
          mdu_a <= req_a[pick];
          mdu_b <= req_b[pick];
        end
        ISSUE: cnt <= '0;
        WAIT: if (mdu_done) begin
          res <= mdu_result;
          err <= 1'b0;
        end else if (timeout) begin
          res <= '0;
          err <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  assign resp = state == RESP;
  assign rsp_valid = resp ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data = resp ? res : '0;
  assign rsp_err = resp & err;
  assign stall_out = req_valid & ~rsp_valid;
  assign mdu_start = state == ISSUE;
  assign mdu_op = op_q;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mdu_share_ctrl.sv
// tb_mdu_share_ctrl: table-driven transactions plus reset and stray-done sequences
module tb_mdu_share_ctrl;
  localparam int XLEN = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid;
  logic [1:0][2:0] req_op;
  logic [1:0][XLEN-1:0] req_a, req_b;
  logic [1:0] stall_out, rsp_valid;
  logic [XLEN-1:0] rsp_data, mdu_a, mdu_b, mdu_result;
  logic rsp_err, mdu_start, mdu_done, busy;
  logic [2:0] mdu_op;
  int n_chk = 0;
  int n_pass = 0;
  mdu_share_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .stall_out(stall_out), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_done(mdu_done), .mdu_result(mdu_result),
    .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] req;
    logic g;
    logic [2:0] op0, op1;
    logic [31:0] a0, b0, a1, b1;
    int done_at;
    logic issue_done;
    logic [31:0] res, exp_data;
    logic exp_err;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic run(input vec_t v);
    logic [1:0] oh;
    int n;
    oh = v.g ? 2'b10 : 2'b01;
    req_valid = v.req;
    req_op[0] = v.op0;
    req_op[1] = v.op1;
    req_a[0] = v.a0;
    req_b[0] = v.b0;
    req_a[1] = v.a1;
    req_b[1] = v.b1;
    mdu_done = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_stall", 32'(stall_out), 32'(v.req));
    @(negedge clk);
    chk("issue_start", 32'(mdu_start), 32'(1));
    chk("issue_op", 32'(mdu_op), 32'(v.g ? v.op1 : v.op0));
    chk("issue_a", mdu_a, v.g ? v.a1 : v.a0);
    chk("issue_b", mdu_b, v.g ? v.b1 : v.b0);
    chk("issue_stall", 32'(stall_out), 32'(v.req));
    mdu_done = v.issue_done;
    mdu_result = 32'hdead_beef;
    n = v.done_at != 0 ? v.done_at : TO;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      mdu_done = (k == v.done_at);
      mdu_result = v.res;
      chk("wait_rsp", 32'(rsp_valid), 32'(0));
      chk("wait_start", 32'(mdu_start), 32'(0));
      chk("wait_stall", 32'(stall_out), 32'(v.req));
    end
    @(negedge clk);
    mdu_done = 1'b0;
    chk("resp_valid", 32'(rsp_valid), 32'(oh));
    chk("resp_data", rsp_data, v.exp_data);
    chk("resp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("resp_stall", 32'(stall_out), 32'(v.req & ~oh));
    chk("resp_busy", 32'(busy), 32'(1));
    req_valid = v.req & ~oh;
    @(negedge clk);
    chk("post_busy", 32'(busy), 32'(0));
    chk("post_rsp", 32'(rsp_valid), 32'(0));
  endtask
  initial begin
    tbl[0] = '{2'b11, 1'b0, 3'd0, 3'd4, 32'd3, 32'd5, 32'd20, 32'd4, 4, 1'b0, 32'd15, 32'd15, 1'b0};
    tbl[1] = '{2'b10, 1'b1, 3'd0, 3'd4, 32'd3, 32'd5, 32'd20, 32'd4, 1, 1'b0, 32'd5, 32'd5, 1'b0};
    tbl[2] = '{2'b11, 1'b0, 3'd3, 3'd6, 32'd7, 32'd6, 32'd17, 32'd5, 2, 1'b0, 32'd42, 32'd42, 1'b0};
    tbl[3] = '{2'b11, 1'b1, 3'd3, 3'd6, 32'd7, 32'd6, 32'd17, 32'd5, 3, 1'b0, 32'd2, 32'd2, 1'b0};
    tbl[4] = '{2'b11, 1'b0, 3'd3, 3'd6, 32'd7, 32'd6, 32'd17, 32'd5, 1, 1'b0, 32'd42, 32'd42, 1'b0};
    tbl[5] = '{2'b11, 1'b1, 3'd3, 3'd6, 32'd7, 32'd6, 32'd17, 32'd5, 5, 1'b0, 32'd2, 32'd2, 1'b0};
    tbl[6] = '{2'b01, 1'b0, 3'd5, 3'd7, 32'd100, 32'd0, 32'd9, 32'd4, 0, 1'b0, 32'h1234, 32'd0, 1'b1};
    tbl[7] = '{2'b10, 1'b1, 3'd5, 3'd7, 32'd100, 32'd0, 32'd9, 32'd4, TO, 1'b0, 32'd1, 32'd1, 1'b0};
    tbl[8] = '{2'b11, 1'b0, 3'd1, 3'd2, 32'hffff_fffe, 32'd2, 32'd1, 32'd1, 2, 1'b0, 32'hffff_ffff, 32'hffff_ffff, 1'b0};
    tbl[9] = '{2'b11, 1'b0, 3'd0, 3'd1, 32'd11, 32'd9, 32'd4, 32'd4, 2, 1'b1, 32'd99, 32'd99, 1'b0};
    rst_n = 1'b0;
    req_valid = 2'b10;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    mdu_done = 1'b0;
    mdu_result = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp", 32'(rsp_valid), 32'(0));
    chk("rst_start", 32'(mdu_start), 32'(0));
    chk("rst_op", 32'(mdu_op), 32'(0));
    chk("rst_a", mdu_a, 32'(0));
    chk("rst_b", mdu_b, 32'(0));
    chk("rst_data", rsp_data, 32'(0));
    chk("rst_err", 32'(rsp_err), 32'(0));
    chk("rst_stall", 32'(stall_out), 32'(2'b10));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run(tbl[i]);
    req_valid = 2'b01;
    req_a[0] = 32'd8;
    req_b[0] = 32'd8;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_rsp", 32'(rsp_valid), 32'(0));
    chk("midrst_start", 32'(mdu_start), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    mdu_done = 1'b1;
    mdu_result = 32'd77;
    @(negedge clk);
    mdu_done = 1'b0;
    chk("stray_busy", 32'(busy), 32'(0));
    chk("stray_rsp", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("stray_busy2", 32'(busy), 32'(0));
    run(tbl[9]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mdu_share_ctrl.md
# mdu_share_ctrl

Arbiter and sequencer that lets the two cores' EX stages share one multi-cycle M-extension unit (MUL/DIV/REM). It accepts one request per core, grants the unit round-robin and runs the start/done handshake to the unit. It stalls each requesting EX stage until its result returns, and enforces a completion timeout. It sits between both EX stages and the shared MDU, at the same level as the per-core pipelines.

## Interface
Parameters:
- XLEN, 32, operand/result width
- TIMEOUT, 64, max cycles in WAIT before abort (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-core request; held high until that core's rsp_valid
- req_op  in  2x3  per-core funct3 (MUL=000 … REMU=111)
- req_a, req_b  in  2xXLEN  per-core operands
- stall_out  out  2  per-core stall to EX stage_in
- rsp_valid  out  2  one-cycle completion pulse per core
- rsp_data  out  XLEN  result, valid only with rsp_valid
- rsp_err  out  1  timeout flag, valid only with rsp_valid
- mdu_start  out  1  one-cycle start pulse to unit
- mdu_op  out  3  latched op
- mdu_a, mdu_b  out  XLEN  latched operands, stable from ISSUE until RESP
- mdu_done  in  1  unit completion pulse
- mdu_result  in  XLEN  unit result, sampled with mdu_done
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, select winner, latch grant, op and operands, then go to ISSUE. Otherwise stay in IDLE.
- Winner selection: if only one core requests, that core wins. If both request, the core selected by rr_ptr wins. After each grant, rr_ptr = ~grant.
- ISSUE: mdu_start=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT: on mdu_done, latch mdu_result, clear err, go to RESP. Otherwise, when the counter reaches TIMEOUT-1, latch result 0, set err, go to RESP. Otherwise increment the counter.
- If mdu_done and the timeout coincide, mdu_done wins and err=0.
- RESP: rsp_valid[grant]=1, rsp_data and rsp_err driven from latches. Next state is unconditionally IDLE.
- stall_out[i] = req_valid[i] & ~(state==RESP & grant==i), combinational.
- A non-granted requester stays stalled through the whole transaction.
- mdu_done outside WAIT is ignored.
- A request dropped mid-transaction still completes. rsp_valid pulses anyway and the core ignores it.
- RESP→IDLE ensures the same instruction, still visible during RESP, is never re-granted.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, counter=0.
  - mdu_start=0, mdu_op=0, mdu_a=mdu_b=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
  - stall_out follows req_valid.
- Request sampled in IDLE at edge t: ISSUE in cycle t+1 (mdu_start high), WAIT from t+2.
- mdu_done in cycle d gives RESP in cycle d+1 and IDLE in d+2.
- Minimum request-to-response is 3 cycles (mdu_done in the first WAIT cycle).
- Timeout: RESP with err occurs TIMEOUT cycles after entering WAIT.
- Back-to-back: the next grant is sampled in the IDLE cycle after RESP, i.e. one idle bubble per transaction.
- Reset mid-operation: immediate return to IDLE, no rsp_valid, mdu_start low. The MDU shares rst_n and aborts too.

## Structure
- Package mdu_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - mdu_op_t (3-bit funct3 encodings MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
  - XLEN and TIMEOUT defaults
- Sub-module rr_arb2 holds the 2-way round-robin pick and rr_ptr register, with an update-enable on grant.
- FSM, operand latches and timeout counter of width $clog2(TIMEOUT) live in mdu_share_ctrl.

## Test plan
- Core0 MUL a=3, b=5; stub asserts mdu_done with 15 on the 4th WAIT cycle. Required: mdu_start one pulse, rsp_valid[0] with rsp_data=15, rsp_err=0. stall_out[0] high until the RESP cycle.
- Both cores request in the same cycle after reset (rr_ptr=0): core0 served first while stall_out[1] stays high. Core1 is granted in the IDLE after core0's RESP. Core1 DIV 20/4 returns 5.
- Both cores request continuously for 4 transactions: grant order alternates 0,1,0,1. No core is granted twice in a row.
- No mdu_done, TIMEOUT=8: rsp_valid[0] with rsp_err=1 and rsp_data=0 arrives 8 cycles after WAIT entry. FSM then returns to IDLE.
- rst_n asserted during WAIT: state IDLE, busy=0, no rsp_valid. A stray mdu_done after reset is ignored.
- mdu_done pulsed in IDLE and ISSUE: no state change and no rsp_valid. Only the WAIT-cycle done produces the response.
